// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MULDIV_FAST_MUL_EN: MUL* ops finish in one edge on a combinational multiplier.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            we_out,
   output logic [1:0]      state_dbg
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [2:0]        op;
   logic              neg;
   logic [XLEN-1:0]   opnd;
   logic [XLEN-1:0]   rem;
   logic [2*XLEN-1:0] acc;

   logic            sign_a, sign_b, a_neg, b_neg, neg_in, special, fast, accept;
   logic [XLEN-1:0] mag_a, mag_b, special_val, fast_val;
   logic [XLEN:0]   add_sum, shifted, diff;

   // Sign-correct the magnitude result and pick the word the opcode asks for.
   function automatic logic [XLEN-1:0] pick(input logic [2:0] f, input logic n,
                                             input logic [2*XLEN-1:0] prod,
                                             input logic [XLEN-1:0] quo,
                                             input logic [XLEN-1:0] rmd);
      logic [2*XLEN-1:0] p;
      p = n ? -prod : prod;
      case (f)
         3'b000:                 pick = p[XLEN-1:0];
         3'b001, 3'b010, 3'b011: pick = p[2*XLEN-1:XLEN];
         3'b100, 3'b101:         pick = n ? -quo : quo;
         default:                pick = n ? -rmd : rmd;
      endcase
   endfunction

   always_comb begin
      sign_a = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
      sign_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      a_neg  = sign_a & a[XLEN-1];
      b_neg  = sign_b & b[XLEN-1];
      mag_a  = a_neg ? -a : a;
      mag_b  = b_neg ? -b : b;
      neg_in = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
      special     = 1'b0;
      special_val = '0;
      if (funct3[2]) begin
         if (b == '0) begin
            special     = 1'b1;
            special_val = funct3[1] ? a : '1;
         end else if (!funct3[0] && a == MIN_INT && b == '1) begin
            special     = 1'b1;
            special_val = funct3[1] ? '0 : MIN_INT;
         end
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   assign fast     = ~funct3[2];
   assign fast_val = pick(funct3, neg_in, {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b}, '0, '0);
`else
   assign fast     = 1'b0;
   assign fast_val = '0;
`endif

   assign busy      = (state == CALC) || (state == FIX);
   assign done      = (state == DONE);
   assign we_out    = done & (|rd_out);
   assign state_dbg = state;
   assign accept    = start & ~busy & ~flush;

   // One iteration of each algorithm; only the one matching op[2] is committed.
   always_comb begin
      add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      shifted = {rem, acc[XLEN-1]};
      diff    = shifted - {1'b0, opnd};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (accept) state_nxt = (special || fast) ? DONE : CALC;
            else        state_nxt = IDLE;
         end
         CALC:    if (cnt == CW'(XLEN-1)) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Mul: opnd=|a|, acc={0,|b|}. Div: opnd=|b| (divisor), acc low word=|a| becomes the quotient.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         op     <= '0;
         neg    <= 1'b0;
         opnd   <= '0;
         rem    <= '0;
         acc    <= '0;
         result <= '0;
         rd_out <= '0;
      end else if (accept) begin
         cnt    <= '0;
         op     <= funct3;
         neg    <= neg_in;
         rd_out <= rd_in;
         rem    <= '0;
         opnd   <= funct3[2] ? mag_b : mag_a;
         acc    <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
         if (special)   result <= special_val;
         else if (fast) result <= fast_val;
      end else if (!flush) begin
         if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (!op[2]) begin
               acc <= {add_sum, acc[XLEN-1:1]};
            end else if (!diff[XLEN]) begin
               rem             <= diff[XLEN-1:0];
               acc[XLEN-1:0]   <= {acc[XLEN-2:0], 1'b1};
            end else begin
               rem             <= shifted[XLEN-1:0];
               acc[XLEN-1:0]   <= {acc[XLEN-2:0], 1'b0};
            end
         end else if (state == FIX) begin
            result <= pick(op, neg, acc, acc[XLEN-1:0], rem);
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic model + expected queues, checked by one compare process.
module tb_muldiv_unit;
   logic        CLK = 1'b0;
   logic        rst;
   logic        start, flush;
   logic [2:0]  funct3;
   logic [31:0] a, b;
   logic [4:0]  rd_in;
   logic        busy, done, we_out;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   logic [31:0] last_exp = '0;

   logic [31:0] exp_q[$];
   logic [4:0]  rd_q[$];
   int          lat_q[$];
   int          st_q[$];
   string       name_q[$];

   muldiv_unit #(.XLEN(32)) dut (
      .CLK(CLK), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
      .a(a), .b(b), .rd_in(rd_in), .busy(busy), .done(done), .result(result),
      .rd_out(rd_out), .we_out(we_out), .state_dbg(state_dbg)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // RV32M semantics in plain 64-bit arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, ux, uy, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'b0, x});
      uy = longint'({32'b0, y});
      case (f)
         3'd0: begin p = ux * uy; return p[31:0]; end
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * uy; return p[63:32]; end
         3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
            r = sx / sy; return r[31:0];
         end
         3'd5: begin
            if (y == 0) return 32'hFFFF_FFFF;
            r = ux / uy; return r[31:0];
         end
         3'd6: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
            r = sx % sy; return r[31:0];
         end
         default: begin
            if (y == 0) return x;
            r = ux % uy; return r[31:0];
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!f[2]) return 1;
`endif
      return 34;
   endfunction

   // Drive start for one edge (call away from posedge), queue the expectation, scramble operands.
   task automatic launch(input string nm, input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] rd);
      int lat;
      lat = exp_lat(f, x, y);
      last_exp = model(f, x, y);
      exp_q.push_back(last_exp);
      rd_q.push_back(rd);
      lat_q.push_back(lat);
      st_q.push_back(edge_cnt + 1);
      name_q.push_back(nm);
      funct3 = f; a = x; b = y; rd_in = rd; start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      funct3 = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom; rd_in = 5'($urandom_range(0, 31));
      chk({nm, "_busy"}, {31'b0, busy}, {31'b0, lat > 1});
   endtask

   task automatic wait_done(input string nm);
      bit got = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge CLK);
         if (done) begin got = 1; break; end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s_timeout: no done within 60 cycles, expected one", nm);
      end
   endtask

   task automatic do_vec(input string nm, input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] rd, input logic [31:0] lit);
      chk({nm, "_model"}, model(f, x, y), lit);
      launch(nm, f, x, y, rd);
      wait_done(nm);
   endtask

   always @(negedge CLK) begin
      if (rst) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: result %h, expected no done", result);
            end else begin
               string nm;
               logic [31:0] e;
               logic [4:0]  r;
               int l, s;
               e = exp_q.pop_front(); r = rd_q.pop_front(); l = lat_q.pop_front();
               s = st_q.pop_front(); nm = name_q.pop_front();
               chk({nm, "_result"}, result, e);
               chk({nm, "_rd"}, {27'b0, rd_out}, {27'b0, r});
               chk({nm, "_we"}, {31'b0, we_out}, {31'b0, r != 0});
               chk({nm, "_latency"}, 32'(edge_cnt - s + 1), 32'(l));
            end
         end else if (we_out) begin
            checks++; errors++;
            $display("FAIL we_without_done: we_out 1, expected 0");
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; a = '0; b = '0; rd_in = '0;
      repeat (3) @(negedge CLK);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rd", {27'b0, rd_out}, 32'd0);
      chk("rst_we", {31'b0, we_out}, 32'd0);
      rst = 1'b1;
      @(negedge CLK);

      // Back-to-back: each op after the first is started in the previous op's DONE cycle.
      do_vec("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
      do_vec("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE);
      do_vec("mulhsu_m1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF);
      do_vec("mulh_min_min", 3'd1, 32'h8000_0000,  32'h8000_0000, 5'd8,  32'h4000_0000);
      do_vec("mulh_m7_3",    3'd1, 32'hFFFF_FFF9,  32'd3,         5'd9,  32'hFFFF_FFFF);
      do_vec("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD);
      do_vec("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFF);
      do_vec("divu_100_7",   3'd5, 32'd100,        32'd7,         5'd12, 32'd14);
      do_vec("remu_100_7",   3'd7, 32'd100,        32'd7,         5'd13, 32'd2);
      do_vec("div_by0",      3'd4, 32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF);
      do_vec("rem_by0",      3'd6, 32'd5,          32'd0,         5'd15, 32'd5);
      do_vec("divu_by0",     3'd5, 32'd5,          32'd0,         5'd16, 32'hFFFF_FFFF);
      do_vec("remu_by0",     3'd7, 32'd5,          32'd0,         5'd17, 32'd5);
      do_vec("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 32'h8000_0000);
      do_vec("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'd0);
      do_vec("div_7_m2",     3'd4, 32'd7,          32'hFFFF_FFFE, 5'd20, 32'hFFFF_FFFD);
      do_vec("rem_7_m2",     3'd6, 32'd7,          32'hFFFF_FFFE, 5'd21, 32'd1);
      do_vec("divu_max_1",   3'd5, 32'hFFFF_FFFF,  32'd1,         5'd22, 32'hFFFF_FFFF);
      do_vec("mul_rd0",      3'd0, 32'd3,          32'd4,         5'd0,  32'd12);

      // A start presented while busy must be ignored (a special-case DIV would finish at once).
      launch("mul_busy", 3'd0, 32'd6, 32'd7, 5'd3);
      repeat (5) @(posedge CLK);
      #1 funct3 = 3'd4; a = 32'd5; b = 32'd0; rd_in = 5'd9; start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      wait_done("mul_busy");
      repeat (3) @(negedge CLK);

      // Flush mid-CALC: no done, result holds.
      funct3 = 3'd5; a = 32'd100; b = 32'd7; rd_in = 5'd4; start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      repeat (10) @(posedge CLK);
      #1 flush = 1'b1;
      @(posedge CLK);
      #1 flush = 1'b0;
      chk("flush_busy", {31'b0, busy}, 32'd0);
      repeat (40) @(negedge CLK);
      chk("flush_result_hold", result, last_exp);

      // Flush and start together: start is discarded.
      #1 funct3 = 3'd4; a = 32'd5; b = 32'd0; rd_in = 5'd2; start = 1'b1; flush = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0; flush = 1'b0;
      @(negedge CLK);
      chk("flush_start_done", {31'b0, done}, 32'd0);
      chk("flush_start_busy", {31'b0, busy}, 32'd0);
      repeat (3) @(negedge CLK);

      // Asynchronous reset mid-CALC clears outputs without waiting for a clock edge.
      funct3 = 3'd5; a = 32'd100; b = 32'd7; rd_in = 5'd4; start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      repeat (10) @(posedge CLK);
      #3 rst = 1'b0;
      #1;
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_done", {31'b0, done}, 32'd0);
      chk("arst_result", result, 32'd0);
      chk("arst_rd", {27'b0, rd_out}, 32'd0);
      chk("arst_we", {31'b0, we_out}, 32'd0);
      @(negedge CLK);
      rst = 1'b1;
      @(negedge CLK);
      do_vec("mul_after_rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);

      repeat (5) @(negedge CLK);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
